// File: rtl/result_collector_pkg.sv
// Shared parameters and FSM encoding for the result collector.
package result_collector_pkg;

  localparam int unsigned ROW_ID_SIZE      = 10;
  localparam int unsigned ACCUMULATOR_SIZE = 48;
  localparam int unsigned NUM_ROWS         = 1024;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // A job size is legal when it is non-zero and fits in the result memory.
  function automatic logic total_ok(input logic [ROW_ID_SIZE:0] total,
                                    input logic [ROW_ID_SIZE:0] max_rows);
    return (total != '0) && (total <= max_rows);
  endfunction

endpackage

// File: rtl/result_collector_ram.sv
// Simple dual-port result storage: one write port, one registered read port.
module result_ram #(
  parameter int unsigned addr_w = 10,
  parameter int unsigned data_w = 48,
  parameter int unsigned depth  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [addr_w-1:0] wr_addr,
  input  logic [data_w-1:0] wr_data,
  input  logic              rd_en,
  input  logic [addr_w-1:0] rd_addr,
  output logic [data_w-1:0] rd_data
);

  logic [data_w-1:0] mem [depth];

  // Array itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read data holds while rd_en is low, which lets it act as a stalled output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/result_collector.sv
// Collects per-row results into memory, then drains them in row order.
// Optional duplicate-write detection: define RESULT_DUP_CHECK_EN.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int unsigned row_id_size      = ROW_ID_SIZE,
  parameter int unsigned accumulator_size = ACCUMULATOR_SIZE,
  parameter int unsigned num_rows         = NUM_ROWS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        write_data,
  input  logic [row_id_size-1:0]      addr_data,
  input  logic [accumulator_size-1:0] data,
  input  logic                        start,
  input  logic [row_id_size:0]        total_rows,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [row_id_size-1:0]      out_addr,
  output logic [accumulator_size-1:0] out_data,
  output logic                        busy,
  output logic                        done,
  output logic [row_id_size:0]        rows_written,
  output logic                        err_range,
  output logic                        err_dup
);

  localparam int unsigned CNT_W = row_id_size + 1;
  localparam logic [CNT_W-1:0] MAX_ROWS = CNT_W'(num_rows);

  state_t           state;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] rd_ptr;

  logic in_range;
  logic row_dup;
  logic wr_en;
  logic rd_en;
  logic last_xfer;
  logic start_take;
  logic start_ok;

  always_comb begin
    in_range   = {1'b0, addr_data} < total_q;
    start_take = start && ((state == S_IDLE) || (state == S_DONE));
    start_ok   = total_ok(total_rows, MAX_ROWS);
    wr_en      = write_data && (state == S_COLLECT) && in_range && !row_dup;
    // Issue a read only when the output slot is free or being emptied this cycle.
    rd_en      = (state == S_DRAIN) && (rd_ptr < total_q) && (!out_valid || out_ready);
    // Every read issued and the final word is leaving.
    last_xfer  = (state == S_DRAIN) && out_valid && out_ready && (rd_ptr == total_q);
  end

`ifdef RESULT_DUP_CHECK_EN
  logic [num_rows-1:0] row_valid;
  logic                err_dup_q;

  assign row_dup = row_valid[addr_data];
  assign err_dup = err_dup_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_valid <= '0;
      err_dup_q <= 1'b0;
    end else if (start_take) begin
      row_valid <= '0;
      if (start_ok) err_dup_q <= 1'b0;
    end else begin
      if (wr_en) row_valid[addr_data] <= 1'b1;
      if (write_data && (state == S_COLLECT) && in_range && row_dup) err_dup_q <= 1'b1;
    end
  end
`else
  assign row_dup = 1'b0;
  assign err_dup = 1'b0;
`endif

  result_ram #(
    .addr_w (row_id_size),
    .data_w (accumulator_size),
    .depth  (num_rows)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (addr_data),
    .wr_data (data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[row_id_size-1:0]),
    .rd_data (out_data)
  );

  // Control FSM with registered status and stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      total_q      <= '0;
      rd_ptr       <= '0;
      rows_written <= '0;
      err_range    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      out_valid    <= 1'b0;
      out_addr     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (write_data) err_range <= 1'b1;
          if (start) begin
            rows_written <= '0;
            rd_ptr       <= '0;
            if (start_ok) begin
              total_q   <= total_rows;
              err_range <= 1'b0;
              state     <= S_COLLECT;
              busy      <= 1'b1;
              done      <= 1'b0;
            end else begin
              err_range <= 1'b1;
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end

        S_COLLECT: begin
          if (write_data && !in_range) err_range <= 1'b1;
          if (wr_en) begin
            rows_written <= rows_written + CNT_W'(1);
            if (rows_written + CNT_W'(1) == total_q) state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (write_data) err_range <= 1'b1;
          if (rd_en) begin
            rd_ptr    <= rd_ptr + CNT_W'(1);
            out_valid <= 1'b1;
            out_addr  <= rd_ptr[row_id_size-1:0];
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
          if (last_xfer) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// Randomized scoreboard bench for result_collector with a row-level reference model.
module tb_result_collector;

  localparam int unsigned RW = 10;
  localparam int unsigned AW = 48;
  localparam int unsigned NR = 1024;
`ifdef RESULT_DUP_CHECK_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write_data = 1'b0;
  logic [RW-1:0] addr_data = '0;
  logic [AW-1:0] data = '0;
  logic          start = 1'b0;
  logic [RW:0]   total_rows = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RW-1:0] out_addr;
  logic [AW-1:0] out_data;
  logic          busy, done, err_range, err_dup;
  logic [RW:0]   rows_written;

  result_collector dut (
    .clk(clk), .rst(rst), .write_data(write_data), .addr_data(addr_data),
    .data(data), .start(start), .total_rows(total_rows),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .busy(busy), .done(done), .rows_written(rows_written),
    .err_range(err_range), .err_dup(err_dup)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [47:0] data;
    bit          known;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   xfer_t[$];
  bit   ready_pat[$];
  bit   ready_rand = 1'b0;

  // Reference model: job-level view of what the collector should hold.
  logic [47:0] mem_m [NR];
  bit          known_m [NR];
  bit          vld_m [NR];
  int          m_total, m_count;
  bit          m_collect, m_err_range, m_err_dup, m_done;

  int   w_addr[$];
  logic [47:0] w_data[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // out_ready driver: explicit pattern first, else random or held high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_pat.size() > 0) out_ready = ready_pat.pop_front();
      else if (ready_rand)      out_ready = 1'($urandom_range(0, 1));
      else                      out_ready = 1'b1;
    end
  end

  // Monitor: stall stability and scoreboard comparison on every transfer.
  bit          stall_prev = 1'b0;
  logic [RW-1:0] h_addr;
  logic [AW-1:0] h_data;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_addr", 64'(out_addr), 64'(h_addr));
          chk("hold_data", 64'(out_data), 64'(h_data));
        end
        if (out_valid && out_ready) begin
          xfer_t.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk("unexpected_xfer_addr", 64'(out_addr), 64'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("drain_addr", 64'(out_addr), 64'(e.addr));
            if (e.known) chk("drain_data", 64'(out_data), 64'(e.data));
          end
        end
        stall_prev = out_valid && !out_ready;
        h_addr = out_addr;
        h_data = out_data;
      end
    end
  end

  task automatic model_reset();
    m_collect = 0; m_err_range = 0; m_err_dup = 0; m_count = 0; m_done = 0; m_total = 0;
    for (int i = 0; i < int'(NR); i++) vld_m[i] = 0;
    exp_q.delete();
  endtask

  task automatic model_start(input int t);
    m_count = 0;
    for (int i = 0; i < int'(NR); i++) vld_m[i] = 0;
    if (t == 0 || t > int'(NR)) begin
      m_err_range = 1; m_collect = 0; m_done = 1;
    end else begin
      m_err_range = 0; m_err_dup = 0; m_total = t; m_collect = 1; m_done = 0;
    end
  endtask

  task automatic model_write(input int a, input logic [47:0] d);
    exp_t e;
    if (m_collect && a < m_total) begin
      if (DUP && vld_m[a]) begin
        m_err_dup = 1;
      end else begin
        mem_m[a] = d; known_m[a] = 1; vld_m[a] = 1;
        m_count++;
        if (m_count == m_total) begin
          m_collect = 0;
          for (int r = 0; r < m_total; r++) begin
            e.addr = r; e.data = mem_m[r]; e.known = known_m[r];
            exp_q.push_back(e);
          end
        end
      end
    end else begin
      m_err_range = 1;
    end
  endtask

  task automatic do_start(input int t);
    start = 1'b1;
    total_rows = (RW+1)'(t);
    tick();
    start = 1'b0;
    model_start(t);
  endtask

  task automatic do_write(input int a, input logic [47:0] d);
    write_data = 1'b1;
    addr_data = RW'(a);
    data = d;
    tick();
    write_data = 1'b0;
    model_write(a, d);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_rows_written"}, 64'(rows_written), 64'(m_count));
    chk({tag, "_err_range"}, 64'(err_range), 64'(m_err_range));
    chk({tag, "_err_dup"}, 64'(err_dup), 64'(m_err_dup));
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      tick();
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    check_status(tag);
  endtask

  // Issue queued writes; optionally stop once the model has left collection.
  task automatic run_writes(input bit stop_early, input int gap_max);
    while (w_addr.size() > 0) begin
      if (stop_early && !m_collect) begin
        w_addr.delete(); w_data.delete();
        break;
      end
      repeat ($urandom_range(0, gap_max)) tick();
      do_write(w_addr.pop_front(), w_data.pop_front());
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_addr"}, 64'(out_addr), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_rows_written"}, 64'(rows_written), 64'd0);
    chk({tag, "_err_range"}, 64'(err_range), 64'd0);
    chk({tag, "_err_dup"}, 64'(err_dup), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(NR); i++) begin known_m[i] = 0; mem_m[i] = '0; end
    model_reset();
    rst = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // Ordered drain with out_ready held high.
    ready_rand = 0;
    do_start(4);
    chk("collect_busy", 64'(busy), 64'd1);
    chk("collect_done", 64'(done), 64'd0);
    xfer_t.delete();
    do_write(2, 48'd20); do_write(0, 48'd0); do_write(3, 48'd30); do_write(1, 48'd10);
    wait_done("basic", 50);
    chk("basic_xfers", 64'(xfer_t.size()), 64'd4);
    if (xfer_t.size() == 4) chk("basic_back_to_back", 64'(xfer_t[3] - xfer_t[0]), 64'd3);

    // Stalled drain.
    do_start(4);
    do_write(1, 48'h111); do_write(3, 48'h333); do_write(0, 48'h100);
    ready_pat = '{1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 1};
    do_write(2, 48'h222);
    wait_done("stall", 100);

    // Out-of-range write is dropped and flagged.
    do_start(4);
    do_write(7, 48'hDEAD);
    chk("oor_err_range", 64'(err_range), 64'd1);
    chk("oor_rows_written", 64'(rows_written), 64'd0);
    chk("oor_busy", 64'(busy), 64'd1);
    for (int r = 0; r < 4; r++) do_write(r, 48'(r * 3 + 1));
    wait_done("oor", 50);

    // Duplicate row write.
    do_start(2);
    w_addr = '{0, 0, 1};
    w_data = '{48'd5, 48'd9, 48'd3};
    run_writes(1'b0, 0);
    wait_done("dup", 50);

    // Reset in the middle of collection, then a one-row job.
    do_start(4);
    do_write(0, 48'hAA); do_write(1, 48'hBB);
    rst = 1'b1;
    #1;
    check_reset_values("midreset");
    model_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
    do_start(1);
    do_write(0, 48'h77);
    wait_done("after_reset", 50);

    // Illegal job sizes.
    do_start(0);
    chk("zero_err_range", 64'(err_range), 64'd1);
    chk("zero_done", 64'(done), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("zero_no_valid", 64'(out_valid), 64'd0);
      tick();
    end
    do_start(NR + 1);
    chk("big_err_range", 64'(err_range), 64'd1);
    chk("big_done", 64'(done), 64'd1);
    chk("big_rows_written", 64'(rows_written), 64'd0);

    // Randomized jobs with stray and duplicate writes and random backpressure.
    ready_rand = 1;
    for (int j = 0; j < 30; j++) begin
      int t;
      int perm[$];
      t = $urandom_range(1, 12);
      do_start(t);
      for (int r = 0; r < t; r++) perm.push_back(r);
      for (int i = t - 1; i > 0; i--) begin
        int k; int tmp;
        k = $urandom_range(0, i);
        tmp = perm[i]; perm[i] = perm[k]; perm[k] = tmp;
      end
      foreach (perm[i]) begin
        if ($urandom_range(0, 7) == 0) begin
          w_addr.push_back(t + $urandom_range(0, 20));
          w_data.push_back(48'($urandom));
        end
        if ($urandom_range(0, 7) == 0 && i > 0) begin
          w_addr.push_back(perm[i - 1]);
          w_data.push_back({16'($urandom), 32'($urandom)});
        end
        w_addr.push_back(perm[i]);
        w_data.push_back({16'($urandom), 32'($urandom)});
      end
      run_writes(1'b1, 2);
      wait_done("rand", 500);
    end

    ready_rand = 0;
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter row_id_size, default 10, meaning row address width.
REQ-002 SHALL have parameter accumulator_size, default 48, meaning result word width.
REQ-003 SHALL have parameter num_rows, default 1024, meaning result memory depth, at most 2**row_id_size.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port write_data, input, 1, a one-cycle result-write strobe from the CISR/accumulator stage.
REQ-007 SHALL have port addr_data, input, row_id_size, the row index of the write.
REQ-008 SHALL have port data, input, accumulator_size, the row result.
REQ-009 SHALL have port start, input, 1, the job start pulse.
REQ-010 SHALL have port total_rows, input, row_id_size+1, rows expected in the job, sampled on start.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_addr (output, row_id_size) and out_data (output, accumulator_size), forming the drain stream.
REQ-012 SHALL have ports busy (output, 1), done (output, 1), rows_written (output, row_id_size+1), err_range (output, 1) and err_dup (output, 1).

Function
REQ-013 SHALL implement FSM states IDLE, COLLECT, DRAIN and DONE.
REQ-014 SHALL, in IDLE or DONE, on start with total_rows > 0: latch total_rows, clear rows_written, err_range and err_dup, and enter COLLECT.
REQ-015 SHALL, on start with total_rows = 0 or total_rows > num_rows: set err_range, clear rows_written, and enter DONE.
REQ-016 SHALL ignore start in COLLECT and DRAIN.
REQ-017 SHALL, in COLLECT, on write_data with addr_data < latched total: write data to mem[addr_data] and increment rows_written, both in the same cycle.
REQ-018 SHALL, on write_data with addr_data >= latched total, or on write_data in any state other than COLLECT, drop the write and set err_range (sticky).
REQ-019 SHALL enter DRAIN on the cycle after rows_written reaches the latched total.
REQ-020 SHALL, in DRAIN, issue sequential memory reads for addresses 0 .. total-1; the memory has one-cycle synchronous read latency.
REQ-021 SHALL keep out_valid, out_addr and out_data stable while out_valid=1 and out_ready=0.
REQ-022 SHALL treat a transfer as occurring on a cycle with out_valid=1 and out_ready=1.
REQ-023 SHALL sustain one transfer per cycle when out_ready is held at 1, after a single-cycle startup bubble.
REQ-024 SHALL enter DONE on the cycle after the transfer of address total-1.
REQ-025 SHALL hold done at 1 in DONE until the next accepted start.
REQ-026 SHALL drive busy = 1 in COLLECT and DRAIN, and 0 otherwise.

Reset
REQ-027 SHALL, on rst asserted at any time, including mid-COLLECT or mid-DRAIN, go to IDLE and drive out_valid=0, out_addr=0, out_data=0, busy=0, done=0, rows_written=0, err_range=0 and err_dup=0.
REQ-028 SHALL NOT require memory contents to be cleared by reset.
REQ-029 SHALL clear the per-row valid bits (when present) on reset and on an accepted start.

Configuration
REQ-030 SHALL support macro RESULT_DUP_CHECK_EN.
REQ-031 SHALL, when RESULT_DUP_CHECK_EN is defined, keep one valid bit per row; a second in-range write to the same row in a job sets err_dup (sticky), and that write is dropped and not counted.
REQ-032 SHALL, when RESULT_DUP_CHECK_EN is undefined, count every in-range write, let the last write win, and tie err_dup to 0.

Structure
REQ-033 SHALL take row_id_size, accumulator_size, num_rows and the FSM state encoding from the shared params package.
REQ-034 SHALL place storage in one sub-module, result_ram: simple dual-port, one write port and one synchronous read port.

Verification
REQ-035 SHALL cover: total_rows=4; writes to rows 2,0,3,1 with data 20,0,30,10; out_ready=1 -> DRAIN outputs (0,0),(1,10),(2,20),(3,30) on consecutive cycles, then done=1.
REQ-036 SHALL cover: out_ready toggling 1,0,0,1 during drain -> no repeated or skipped address, and outputs held stable while stalled.
REQ-037 SHALL cover: total_rows=4 and a write to addr 7 -> err_range=1, rows_written unchanged, no write to memory.
REQ-038 SHALL cover: with RESULT_DUP_CHECK_EN, total_rows=2 and writes row0=5, row0=9, row1=3 -> err_dup=1, drain outputs 5,3; without the macro, DRAIN is entered after the second write and outputs 9 for row 0, with row 1 unwritten.
REQ-039 SHALL cover: rst asserted after 2 of 4 writes -> all outputs return to reset values; a new start with total_rows=1 and one write completes normally.
REQ-040 SHALL cover: start with total_rows=0 -> err_range=1 and done=1 with no out_valid.
